// File: rtl/burst_memory_if.sv
// burst_memory_if: request/response bundle between a MIPS stage (master)
// and burst_memory (slave).
//   address     - byte address of beat 0, sampled when a request is accepted
//   data_in     - write beat data, big-endian ([31:24] = lowest byte address)
//   access_size - burst length: 00=1, 01=4, 10=8, 11=16 words
//   rw          - 1=write, 0=read
//   enable      - request strobe; ignored while busy
//   busy        - burst in progress
//   data_out    - read beat data, big-endian
//   data_valid  - data_out carries a read beat this cycle
//   err         - faulty-request pulse (only when MEM_ERR_EN is defined)
interface burst_memory_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
`ifdef MEM_ERR_EN
  logic        err;
`endif

  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out, data_valid
`ifdef MEM_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out, data_valid
`ifdef MEM_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/burst_memory.sv
// burst_memory: word-oriented, byte-addressed big-endian memory with a base
// address. Single-word and 4/8/16-word bursts, read and write, over an
// enable/busy handshake.
//   clock - rising-edge clock
//   reset - synchronous, active-high; aborts any burst, memory is not cleared
//   bus   - burst_memory_if.slave (request in, busy/data_out/data_valid out)
// Optional macro MEM_ERR_EN: adds bus.err and request range/alignment
// checking. Without it, address[1:0] is ignored and offsets wrap modulo
// DEPTH_BYTES.
module burst_memory #(
  parameter int unsigned DEPTH_BYTES = 1048576,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
  input  logic clock,
  input  logic reset,
  burst_memory_if.slave bus
);
  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int          AW    = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;    // word offset of the next beat
  logic [3:0]    r_cnt;    // beats remaining after the current one
  logic          r_busy;
  logic          r_valid;
  logic [31:0]   r_dout;
  logic [31:0]   r_mem [WORDS];

  // Word offset of beat 0; the subtraction wraps naturally, and keeping only
  // the low bits gives the modulo-DEPTH_BYTES behaviour.
  logic [31:0]   w_off;
  logic [AW-1:0] w_word;
  logic [3:0]    w_last;
  logic          w_accept;
  logic          w_fault;
  logic          w_go;
  logic          w_we;
  logic [AW-1:0] w_waddr;

  assign w_off    = bus.address - BASE_ADDR;
  assign w_word   = w_off[AW+1:2];
  assign w_accept = (r_state == IDLE) && bus.enable;

  always_comb begin
    w_last = 4'd0;
    case (bus.access_size)
      2'b00:   w_last = 4'd0;
      2'b01:   w_last = 4'd3;
      2'b10:   w_last = 4'd7;
      default: w_last = 4'd15;
    endcase
  end

`ifdef MEM_ERR_EN
  logic [4:0]  w_n;
  logic [32:0] w_end;
  logic [32:0] w_limit;
  logic        r_err;

  // 33-bit sums so a burst near the top of the address space cannot wrap.
  assign w_n     = {1'b0, w_last} + 5'd1;
  assign w_end   = {1'b0, bus.address} + {26'd0, w_n, 2'b00};
  assign w_limit = {1'b0, BASE_ADDR} + 33'(DEPTH_BYTES);
  assign w_fault = (bus.address[1:0] != 2'b00) || (bus.address < BASE_ADDR) ||
                   (w_end > w_limit);
  assign bus.err = r_err;
`else
  assign w_fault = 1'b0;
`endif

  logic w_unused_off;
  assign w_unused_off = ^{w_off[31:AW+2], w_off[1:0]};

  // A faulty request is consumed (err pulse) but never leaves IDLE.
  assign w_go = w_accept && !w_fault;

  // Beat 0 of a write lands at the acceptance edge; later beats while the
  // counter is nonzero. The cycle with r_cnt==0 in WRITE is the turnaround.
  assign w_we    = !reset && ((w_go && bus.rw) || (r_state == WRITE && r_cnt != 4'd0));
  assign w_waddr = (r_state == IDLE) ? w_word : r_ptr;

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_dout  <= 32'd0;
`ifdef MEM_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
`ifdef MEM_ERR_EN
      r_err <= w_accept && w_fault;
`endif
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_cnt  <= w_last;
            r_ptr  <= w_word + 1'b1;
            r_busy <= 1'b1;
            if (bus.rw) begin
              r_state <= WRITE;
            end else begin
              // Beat 0 is fetched at acceptance: one-cycle read latency.
              r_state <= READ;
              r_valid <= 1'b1;
              r_dout  <= r_mem[w_word];
            end
          end
        end
        READ: begin
          if (r_cnt != 4'd0) begin
            r_dout <= r_mem[r_ptr];
            r_ptr  <= r_ptr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        end
        WRITE: begin
          if (r_cnt != 4'd0) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.data_valid = r_valid;
  assign bus.data_out   = r_dout;
endmodule
